// File: rtl/sdram_pkg.sv
// Constants and types shared by the SDRAM Avalon-MM read and write wrappers.
// Addresses are byte addresses and are always aligned to a data beat.
package sdram_pkg;

   localparam int unsigned SDRAM_DATA_W_DEF = 128;
   localparam int unsigned ADDR_W_DEF       = 32;
   localparam int unsigned BURST_W_DEF      = 11;
   localparam int unsigned BYTES_PER_BEAT   = SDRAM_DATA_W_DEF / 8;

   typedef enum logic [1:0] {
      StIdle,
      StFill,
      StBurst,
      StDone
   } write_state_t;

   function automatic int unsigned beat_bytes(input int unsigned data_w);
      return data_w / 8;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a head-of-queue data output and an occupancy count.
// Pushing while full and popping while empty are both ignored.
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FullCount = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      count_q;
   logic             do_push, do_pop;

   assign full    = (count_q == FullCount);
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem_q[rd_ptr_q];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage needs no reset; the pointers define which entries are live.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data;
   end

endmodule

// File: rtl/avmm_sdram_write_wrapper.sv
// Packs a stream of result beats into Avalon-MM burst writes toward the SDRAM
// controller. A burst is launched only once all of its beats are buffered.
module avmm_sdram_write_wrapper
   import sdram_pkg::*;
#(
   parameter int unsigned SDRAM_DATA_W = SDRAM_DATA_W_DEF,
   parameter int unsigned ADDR_W       = ADDR_W_DEF,
   parameter int unsigned BURST_W      = BURST_W_DEF,
   parameter int unsigned MAX_BURST    = 64,
   parameter int unsigned FIFO_DEPTH   = 64
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [ADDR_W-1:0]         write_addr,
   input  logic [31:0]               write_cnt,
   input  logic                      write_start,
   input  logic [SDRAM_DATA_W-1:0]   write_data,
   input  logic                      write_valid,
   output logic                      write_ready,
   output logic                      write_done,
   output logic                      busy,
   output logic [ADDR_W-1:0]         address,
   output logic [BURST_W-1:0]        burstcount,
   output logic                      write,
   output logic [SDRAM_DATA_W-1:0]   writedata,
   output logic [SDRAM_DATA_W/8-1:0] byteenable,
   input  logic                      waitrequest
);

   localparam int unsigned BYTES = beat_bytes(SDRAM_DATA_W);
   localparam int unsigned CW    = $clog2(FIFO_DEPTH) + 1;

   write_state_t state_q, state_d;

   logic [ADDR_W-1:0]  cur_addr_q;
   logic [ADDR_W-1:0]  address_q;
   logic [BURST_W-1:0] burstcount_q;
   logic [BURST_W-1:0] beat_left_q;
   logic [31:0]        in_left_q;
   logic [31:0]        out_left_q;

   logic [31:0]        blen_w;
   logic [BURST_W-1:0] blen;
   logic               fifo_ready;
   logic               start_ok;
   logic               push, accept, last_beat;

   logic               fifo_full, fifo_empty;
   logic [CW-1:0]      fifo_count;

   sync_fifo #(
      .WIDTH (SDRAM_DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data (write_data),
      .pop       (accept),
      .head      (writedata),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   assign blen_w     = (out_left_q < 32'(MAX_BURST)) ? out_left_q : 32'(MAX_BURST);
   assign blen       = BURST_W'(blen_w);
   assign fifo_ready = (32'(fifo_count) >= blen_w);
   assign start_ok   = write_start && (write_cnt != '0);
   assign push       = write_valid && write_ready;
   assign accept     = write && !waitrequest && !fifo_empty;
   assign last_beat  = accept && (beat_left_q == BURST_W'(1));

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= StIdle;
      else        state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (write_start) state_d = start_ok ? StFill : StDone;
         end
         StFill: begin
            if (fifo_ready) state_d = StBurst;
         end
         StBurst: begin
            if (last_beat) state_d = (out_left_q == 32'd1) ? StDone : StFill;
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Outputs decoded from the registered state only, so reset clears them at once
   always_comb begin
      write       = (state_q == StBurst);
      busy        = (state_q == StFill) || (state_q == StBurst);
      write_done  = (state_q == StDone);
      write_ready = busy && !fifo_full && (in_left_q != '0);
      address     = address_q;
      burstcount  = burstcount_q;
      byteenable  = '1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_addr_q   <= '0;
         address_q    <= '0;
         burstcount_q <= '0;
         beat_left_q  <= '0;
         in_left_q    <= '0;
         out_left_q   <= '0;
      end else begin
         if (state_q == StIdle && start_ok) begin
            cur_addr_q <= write_addr;
            in_left_q  <= write_cnt;
            out_left_q <= write_cnt;
         end
         if (push) in_left_q <= in_left_q - 32'd1;
         if (state_q == StFill && fifo_ready) begin
            address_q    <= cur_addr_q;
            burstcount_q <= blen;
            beat_left_q  <= blen;
         end
         if (accept) begin
            out_left_q  <= out_left_q - 32'd1;
            beat_left_q <= beat_left_q - BURST_W'(1);
         end
         // Address wraps naturally modulo 2^ADDR_W
         if (last_beat) begin
            cur_addr_q <= cur_addr_q + ADDR_W'(burstcount_q) * ADDR_W'(BYTES);
         end
      end
   end

endmodule
